// File: rtl/seg_rx_pkg.sv
// Shared constants and types for the seven-segment read-back decoder.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_rx_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
  localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
  localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
  localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
  localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
  localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
  localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
  localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
  localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
  localparam logic [6:0] SEG_PAT_9 = 7'b0010000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low seven-segment pattern to a BCD digit.
// Non-digit patterns return digit 0 with is_digit low.
module seg7_to_bcd
  import seg_rx_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_digit
);

  // Table lookup against the ten legal patterns
  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b1;
    case (pattern)
      SEG_PAT_0: digit = 4'd0;
      SEG_PAT_1: digit = 4'd1;
      SEG_PAT_2: digit = 4'd2;
      SEG_PAT_3: digit = 4'd3;
      SEG_PAT_4: digit = 4'd4;
      SEG_PAT_5: digit = 4'd5;
      SEG_PAT_6: digit = 4'd6;
      SEG_PAT_7: digit = 4'd7;
      SEG_PAT_8: digit = 4'd8;
      SEG_PAT_9: digit = 4'd9;
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_rx_decoder.sv
// Read-back decoder for the two-digit seven-segment seconds display.
// Filters glitches with a stability window, decodes accepted pairs to 0..99,
// flags illegal patterns and checks successive values against counting rules.
// Optional macro SEG_STEP_CHECK_EN enables the step_err comparator; without it
// step_err is tied low and only the 99->0 wrap is detected.
module seg_rx_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  output logic [6:0] value,
  output logic       valid,
  output logic       blank,
  output logic       bad_pattern,
  output logic       wrap,
  output logic       step_err
);

  import seg_rx_pkg::*;

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [13:0] sreg;
  logic [7:0]  cnt;
  state_t      state;

  logic [13:0] pins_c;
  logic        load_c;
  logic        accept_c;
  logic        blank_pair_c;
  logic        legal_c;
  logic [6:0]  new_val_c;
  logic [3:0]  hi_digit;
  logic [3:0]  lo_digit;
  logic        hi_ok;
  logic        lo_ok;

  // Decode the held sample; an accepted pair always equals sreg
  seg7_to_bcd u_tens (
    .pattern  (sreg[13:7]),
    .digit    (hi_digit),
    .is_digit (hi_ok)
  );

  seg7_to_bcd u_units (
    .pattern  (sreg[6:0]),
    .digit    (lo_digit),
    .is_digit (lo_ok)
  );

  // Stability window compare and pair classification
  always_comb begin
    pins_c       = {seg1, seg0};
    load_c       = (cnt == 8'd0) || (pins_c != sreg);
    accept_c     = !load_c && ((cnt + 8'd1) == STABLE_CNT);
    blank_pair_c = (sreg == {SEG_BLANK, SEG_BLANK});
    legal_c      = hi_ok && lo_ok;
    new_val_c    = 7'(hi_digit) * 7'd10 + 7'(lo_digit);
  end

`ifdef SEG_STEP_CHECK_EN
  logic [6:0] prev_inc_c;
  logic       step_ok_c;

  // Legal successors of the held value: repeat, +1, or clear to zero
  always_comb begin
    prev_inc_c = value + 7'd1;
    step_ok_c  = (new_val_c == value) || (new_val_c == prev_inc_c) ||
                 (new_val_c == 7'd0);
  end
`endif

  // Filter, FSM and registered outputs
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sreg        <= 14'h3FFF;
      cnt         <= 8'd0;
      state       <= IDLE;
      value       <= 7'd0;
      valid       <= 1'b0;
      blank       <= 1'b0;
      bad_pattern <= 1'b0;
      wrap        <= 1'b0;
      step_err    <= 1'b0;
    end else begin
      bad_pattern <= 1'b0;
      wrap        <= 1'b0;
      step_err    <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= 8'd0;
        valid <= 1'b0;
        blank <= 1'b0;
      end else begin
        if (load_c) begin
          sreg <= pins_c;
          cnt  <= 8'd1;
        end else if (cnt != STABLE_CNT) begin
          cnt <= cnt + 8'd1;
        end

        if (accept_c) begin
          if (blank_pair_c) begin
            blank <= 1'b1;
            valid <= 1'b0;
            state <= IDLE;
          end else if (legal_c) begin
            if (state == LOCKED) begin
              if ((value == 7'd99) && (new_val_c == 7'd0)) begin
                wrap <= 1'b1;
              end
`ifdef SEG_STEP_CHECK_EN
              else if (!step_ok_c) begin
                step_err <= 1'b1;
              end
`endif
            end
            value <= new_val_c;
            valid <= 1'b1;
            blank <= 1'b0;
            state <= LOCKED;
          end else begin
            bad_pattern <= 1'b1;
            valid       <= 1'b0;
            blank       <= 1'b0;
            state       <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_rx_decoder.sv
// Self-checking bench for seg_rx_decoder: behavioural run-length model,
// per-cycle compare on the falling edge, directed scenarios and random traffic.
module tb_seg_rx_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic [6:0] seg1;
  logic [6:0] seg0;
  logic [6:0] value;
  logic       valid;
  logic       blank;
  logic       bad_pattern;
  logic       wrap;
  logic       step_err;

  int n_tests = 0;
  int n_fail  = 0;

  int bad_cnt  = 0;
  int wrap_cnt = 0;
  int err_cnt  = 0;

  seg_rx_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .clear       (clear),
    .en          (en),
    .seg1        (seg1),
    .seg0        (seg0),
    .value       (value),
    .valid       (valid),
    .blank       (blank),
    .bad_pattern (bad_pattern),
    .wrap        (wrap),
    .step_err    (step_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int digit_of(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (pat(d) == p) return d;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run length of identical samples, accept at the Nth
  int         m_run;
  logic [13:0] m_prev;
  bit         m_locked;
  int         m_value;
  bit         m_valid, m_blank, m_bad, m_wrap, m_err;

  always @(posedge clk or posedge clear) begin
    logic [13:0] pins;
    int hi, lo, n;
    if (clear) begin
      m_run = 0; m_prev = '1; m_locked = 0; m_value = 0;
      m_valid = 0; m_blank = 0; m_bad = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_bad = 0; m_wrap = 0; m_err = 0;
      pins = {seg1, seg0};
      if (!en) begin
        m_run = 0; m_locked = 0; m_valid = 0; m_blank = 0;
      end else begin
        if (m_run == 0 || pins != m_prev) begin
          m_prev = pins;
          m_run  = 1;
        end else begin
          m_run++;
        end
        if (m_run == STABLE) begin
          hi = digit_of(pins[13:7]);
          lo = digit_of(pins[6:0]);
          if (pins == 14'h3FFF) begin
            m_blank = 1; m_valid = 0; m_locked = 0;
          end else if (hi >= 0 && lo >= 0) begin
            n = 10 * hi + lo;
            if (m_locked) begin
              if (m_value == 99 && n == 0) m_wrap = 1;
`ifdef SEG_STEP_CHECK_EN
              else if (!(n == m_value || n == m_value + 1 || n == 0)) m_err = 1;
`endif
            end
            m_value = n; m_valid = 1; m_blank = 0; m_locked = 1;
          end else begin
            m_bad = 1; m_valid = 0; m_blank = 0; m_locked = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus pulse tallies
  always @(negedge clk) begin
    if (!clear) begin
      chk("value", int'(value), m_value);
      chk("valid", int'(valid), int'(m_valid));
      chk("blank", int'(blank), int'(m_blank));
      chk("bad_pattern", int'(bad_pattern), int'(m_bad));
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("step_err", int'(step_err), int'(m_err));
      chk("pulse_onehot", int'(bad_pattern) + int'(wrap) + int'(step_err) > 1, 0);
      if (bad_pattern) bad_cnt++;
      if (wrap) wrap_cnt++;
      if (step_err) err_cnt++;
    end
  end

  task automatic hold(input logic [6:0] a, input logic [6:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      seg1 = a;
      seg0 = b;
      @(negedge clk);
    end
    #1;
  endtask

  task automatic hold_val(input int v, input int n);
    hold(pat(v / 10), pat(v % 10), n);
  endtask

  int snap_bad, snap_wrap, snap_err;

  task automatic snap();
    snap_bad = bad_cnt; snap_wrap = wrap_cnt; snap_err = err_cnt;
  endtask

  initial begin
    int cur, op, len, v;
    clear = 1'b1; en = 1'b0; seg1 = 7'h7F; seg0 = 7'h7F;
    #12;
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_pulses", int'({bad_pattern, wrap, step_err, blank}), 0);
    @(negedge clk); #1;
    clear = 1'b0; en = 1'b1;

    // Reset then blank
    hold(7'h7F, 7'h7F, 4);
    chk("blank_after4", int'(blank), 1);
    chk("blank_valid", int'(valid), 0);

    // Legal 05: 3 edges no change, 4th edge accepts
    hold(pat(0), pat(5), 3);
    chk("p05_3edge_valid", int'(valid), 0);
    chk("p05_3edge_blank", int'(blank), 1);
    hold(pat(0), pat(5), 1);
    chk("p05_value", int'(value), 5);
    chk("p05_valid", int'(valid), 1);

    // Wrap 98 -> 99 -> 00
    hold_val(98, 10);
    snap();
    hold_val(99, 10);
    hold_val(0, 10);
    chk("wrap_count", wrap_cnt - snap_wrap, 1);
    chk("wrap_no_err", err_cnt - snap_err, 0);
    chk("wrap_value", int'(value), 0);

    // Skipped count 12 -> 15
    hold_val(12, 10);
    snap();
    hold_val(15, 10);
`ifdef SEG_STEP_CHECK_EN
    chk("skip_err_count", err_cnt - snap_err, 1);
`else
    chk("skip_err_count", err_cnt - snap_err, 0);
`endif
    chk("skip_value", int'(value), 15);
    chk("skip_valid", int'(valid), 1);

    // Illegal units pattern, then legal 07 from IDLE
    snap();
    hold(pat(0), 7'b0000001, 10);
    chk("illegal_bad_count", bad_cnt - snap_bad, 1);
    chk("illegal_valid", int'(valid), 0);
    chk("illegal_value_held", int'(value), 15);
    snap();
    hold_val(7, 10);
    chk("after_illegal_valid", int'(valid), 1);
    chk("after_illegal_err", err_cnt - snap_err, 0);
    chk("after_illegal_value", int'(value), 7);

    // Glitch: 20, one-cycle 28, back to 20
    hold_val(20, 10);
    snap();
    hold_val(28, 1);
    hold_val(20, 10);
    chk("glitch_value", int'(value), 20);
    chk("glitch_pulses", (bad_cnt - snap_bad) + (wrap_cnt - snap_wrap) + (err_cnt - snap_err), 0);

    // en low forces valid off, value held
    en = 1'b0;
    hold_val(20, 3);
    chk("en_low_valid", int'(valid), 0);
    chk("en_low_value", int'(value), 20);
    en = 1'b1;
    hold_val(21, 4);
    chk("en_back_value", int'(value), 21);

    // Async clear mid-window
    hold_val(33, 2);
    clear = 1'b1;
    #1;
    chk("clr_value", int'(value), 0);
    chk("clr_flags", int'({valid, blank, bad_pattern, wrap, step_err}), 0);
    #1;
    clear = 1'b0;
    @(negedge clk); #1;

    // Randomized traffic
    cur = 0;
    for (int it = 0; it < 1500; it++) begin
      op  = int'($urandom_range(0, 99));
      len = int'($urandom_range(1, 8));
      en  = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
      if (op < 55) begin
        cur = (cur + 1) % 100; hold_val(cur, len);
      end else if (op < 65) begin
        hold_val(cur, len);
      end else if (op < 72) begin
        cur = 0; hold_val(cur, len);
      end else if (op < 82) begin
        v = int'($urandom_range(0, 99)); cur = v; hold_val(cur, len);
      end else if (op < 88) begin
        hold(7'h7F, 7'h7F, len);
      end else if (op < 97) begin
        hold(7'($urandom), 7'($urandom), len);
      end else begin
        clear = 1'b1;
        #2;
        clear = 1'b0;
        @(negedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_rx_decoder.md
# seg_rx_decoder

Receiving end of the two-digit seven-segment display bus driven by the 0–99 seconds counter. It samples the active-low `seg1` and `seg0` digit patterns and filters glitches with a stability window. It then decodes each accepted pair back to a binary value, flags illegal patterns, and checks that successive values follow the counter's +1 / wrap / clear rules. It sits next to the counter on the board as a self-check and read-back path; `wrap` mirrors the counter's `endone`.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pair is accepted. Legal range 2..255.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `en`  in  1  decode enable. Low forces the IDLE state synchronously.
- `seg1`  in  7  tens-digit pattern, active-low.
- `seg0`  in  7  units-digit pattern, active-low.
- `value`  out  7  last accepted decoded value, 0..99.
- `valid`  out  1  `value` reflects the currently displayed, legal pair.
- `blank`  out  1  the accepted pair is both digits off (7'b1111111).
- `bad_pattern`  out  1  one-cycle pulse: the accepted pair is illegal.
- `wrap`  out  1  one-cycle pulse: an accepted step from 99 to 0.
- `step_err`  out  1  one-cycle pulse: an accepted step violates the counting rules.

## Operation
- **Digit patterns**, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- **Stability filter**
  - Sample register `sreg` (14 bits) and counter `cnt` (8 bits).
  - If `cnt`==0 or the pins differ from `sreg`: load the pins into `sreg` and set `cnt`=1.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
  - Acceptance fires exactly once per stable run, on the edge where `cnt` becomes `STABLE_CYCLES`.
- **Classification of an accepted pair**
  - Both digits 7F: blank. Result: `blank`=1, `valid`=0, state IDLE, `value` unchanged.
  - Both digits in the pattern table: legal. Result: `value`=10·hi+lo, `valid`=1, `blank`=0, state LOCKED.
  - Anything else, including one digit blank and one lit: illegal. Result: `bad_pattern` pulse, `valid`=0, `blank`=0, state IDLE, `value` unchanged.
- **FSM** has two states, IDLE and LOCKED.
  - A step check runs only on a legal accept while in LOCKED, comparing the new value N against the held value P.
  - N==P: no pulse (the same value returned after a glitch).
  - N==P+1 with P≤98: no pulse.
  - P==99 and N==0: `wrap` pulse.
  - N==0 otherwise: counter clear, no pulse.
  - Any other N: `step_err` pulse.
  - A legal accept from IDLE never raises `step_err` or `wrap`.
- **`en` low**, checked synchronously each edge:
  - state IDLE, `cnt`=0;
  - `valid`, `blank` and all pulses forced to 0;
  - `value` holds.
- **Arithmetic**: P+1 is computed in 7 bits. The tens×10 product is formed in 7 bits; the maximum is 99, so there is no overflow.

## Timing
- **Reset values**: `value`=0, `valid`=0, `blank`=0, `bad_pattern`=0, `wrap`=0, `step_err`=0. Internally `sreg`=14'h3FFF, `cnt`=0, state IDLE.
- **Latency**: when a pair is first sampled at edge k and held, outputs update at edge k+`STABLE_CYCLES`−1. With the default of 4, that is the 4th sampling edge.
- **Glitch rejection**: a pair held for fewer than `STABLE_CYCLES` edges causes no output change.
- **Pulses** last exactly one cycle, aligned with the accept edge. At most one of `bad_pattern`, `wrap`, `step_err` is high in any cycle.
- **`clear` asserted mid-window or mid-pulse**: all outputs return to reset values immediately, without waiting for a clock edge.

## Configuration
- `SEG_STEP_CHECK_EN` defined: step checking as described above.
- `SEG_STEP_CHECK_EN` undefined:
  - `step_err` is tied to 0;
  - the P/N comparator is removed;
  - `wrap` is still generated: on a legal accept in LOCKED with P==99 and N==0.

## Structure
- **Package `seg_rx_pkg`** holds:
  - the ten digit pattern constants;
  - the blank constant 7'h7F;
  - the state enum (IDLE, LOCKED).
- **Sub-module `seg7_to_bcd`**: combinational, 7-bit pattern in, 4-bit digit plus `is_digit` out. It is instantiated twice, once for the tens digit and once for the units digit.

## Test plan
- **Reset then blank**: pulse `clear`, `en`=1, drive `seg1`=`seg0`=7F for 4 edges → `blank`=1 after the 4th edge, `valid`=0.
- **Legal pair, 05**: `seg1`=1000000, `seg0`=0010010 held 4 edges → `value`=5, `valid`=1. The same pair held only 3 edges → no change.
- **Wrap**: 98, 99, 00, each held 10 cycles → single `wrap` pulse on the 00 accept, `step_err` stays 0, `value`=0.
- **Skipped count**: 12 then 15 → one `step_err` pulse, `value`=15, `valid`=1. With `SEG_STEP_CHECK_EN` undefined, `step_err` stays 0.
- **Illegal pattern**: `seg0`=0000001 (tens digit legal) → one `bad_pattern` pulse, `valid`=0. A following legal 07 → `valid`=1 with no `step_err`.
- **Glitch and async clear**:
  - 20 stable, a 1-cycle 28, then back to 20 → no output change and no pulses.
  - `clear` asserted mid-window → all outputs read 0 before the next edge.
